// File: rtl/uart_pkg.sv
// Types, parity modes and the parity helper shared by the fabric UART
// and its testbench-visible configuration.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with an occupancy count.
// The head reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Ready comes from the level alone, so a pop never frees a slot in the same cycle.
  assign wr_ready = (level != (AW+1)'(DEPTH));
  assign rd_valid = (level != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// Parametrised UART with TX/RX FIFOs, configurable frame format and
// one-cycle error pulses aligned with the RX FIFO push.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 1736,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic                          uart_rxd,
  output logic                          uart_txd,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          tx_busy,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun
);

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);
  localparam bit          HAS_PARITY  = (PARITY != PAR_NONE);

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_head_valid;
  logic                 tx_pop;
  logic                 rx_push_q;
  logic [DATA_BITS-1:0] rx_word_q;
  logic                 rx_fifo_ready;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (sys_clk),
    .reset    (reset),
    .wr_data  (tx_data),
    .wr_valid (tx_valid),
    .wr_ready (tx_ready),
    .rd_data  (tx_head),
    .rd_valid (tx_head_valid),
    .rd_ready (tx_pop),
    .level    (tx_level)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk      (sys_clk),
    .reset    (reset),
    .wr_data  (rx_word_q),
    .wr_valid (rx_push_q),
    .wr_ready (rx_fifo_ready),
    .rd_data  (rx_data),
    .rd_valid (rx_valid),
    .rd_ready (rx_ready),
    .level    (rx_level)
  );

  uart_state_t          tx_state, tx_state_n;
  logic [15:0]          tx_baud, tx_baud_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_line;
  logic                 tx_tick;

  assign tx_tick = (tx_baud == '0);
  assign tx_busy = (tx_state != ST_IDLE) || (tx_level != '0);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      uart_txd <= tx_line;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_tick ? BAUD_RELOAD : tx_baud - 16'd1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    unique case (tx_state)
      ST_IDLE: begin
        tx_baud_n = BAUD_RELOAD;
        tx_pop    = tx_head_valid;
      end
      ST_START: begin
        tx_line = 1'b0;
        if (tx_tick) begin
          tx_state_n = ST_DATA;
          tx_bit_n   = '0;
        end
      end
      ST_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick) begin
          tx_shift_n = tx_shift >> 1;
          tx_bit_n   = tx_bit + 4'd1;
          if (tx_bit == LAST_DATA) begin
            tx_bit_n   = '0;
            tx_state_n = HAS_PARITY ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        tx_line = tx_par;
        if (tx_tick) tx_state_n = ST_STOP;
      end
      ST_STOP: begin
        if (tx_tick) begin
          tx_bit_n = tx_bit + 4'd1;
          if (tx_bit == LAST_STOP) begin
            tx_bit_n   = '0;
            tx_state_n = ST_IDLE;
            tx_pop     = tx_head_valid;
          end
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase
    // Popping straight out of the last stop bit keeps back-to-back frames gapless.
    if (tx_pop) begin
      tx_state_n = ST_START;
      tx_baud_n  = BAUD_RELOAD;
      tx_shift_n = tx_head;
      tx_par_n   = parity_bit(8'(tx_head), PARITY);
    end
  end

  logic                 rxd_meta, rxd_sync;
  uart_state_t          rx_state, rx_state_n;
  logic [15:0]          rx_baud, rx_baud_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_par, rx_par_n;
  logic                 rx_armed, rx_armed_n;
  logic                 rx_done;
  logic                 rx_tick;
  logic                 rx_ferr_q, rx_perr_q;

  assign rx_tick       = (rx_baud == '0);
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_overrun    = rx_push_q && !rx_fifo_ready;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rx_state  <= ST_IDLE;
      rx_baud   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      rx_armed  <= 1'b1;
      rx_push_q <= 1'b0;
      rx_word_q <= '0;
      rx_ferr_q <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      rxd_meta  <= uart_rxd;
      rxd_sync  <= rxd_meta;
      rx_state  <= rx_state_n;
      rx_baud   <= rx_baud_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      rx_par    <= rx_par_n;
      rx_armed  <= rx_armed_n;
      rx_push_q <= rx_done;
      if (rx_done) rx_word_q <= rx_shift;
      rx_ferr_q <= rx_done && !rxd_sync;
      rx_perr_q <= rx_done && HAS_PARITY && (rx_par != parity_bit(8'(rx_shift), PARITY));
    end
  end

  // After a bad stop bit the receiver stays disarmed until it sees the line high.
  always_comb begin
    rx_state_n = rx_state;
    rx_baud_n  = rx_tick ? BAUD_RELOAD : rx_baud - 16'd1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_armed_n = rx_armed;
    rx_done    = 1'b0;
    unique case (rx_state)
      ST_IDLE: begin
        rx_baud_n = HALF_RELOAD;
        if (!rx_armed) rx_armed_n = rxd_sync;
        else if (!rxd_sync) rx_state_n = ST_START;
      end
      ST_START: begin
        if (rx_tick) begin
          rx_state_n = rxd_sync ? ST_IDLE : ST_DATA;
          rx_bit_n   = '0;
        end
      end
      ST_DATA: begin
        if (rx_tick) begin
          rx_shift_n = {rxd_sync, rx_shift[DATA_BITS-1:1]};
          rx_bit_n   = rx_bit + 4'd1;
          if (rx_bit == LAST_DATA) begin
            rx_bit_n   = '0;
            rx_state_n = HAS_PARITY ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (rx_tick) begin
          rx_par_n   = rxd_sync;
          rx_state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_tick) begin
          rx_done    = 1'b1;
          rx_state_n = ST_IDLE;
          rx_armed_n = rxd_sync;
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: 8N1 loopback instance, 8E1 receive instance, 4-deep overrun instance.
module tb_uart_fifo_core;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] a_tx_data, a_rx_data;
  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready, a_txd;
  logic [4:0] a_tx_level, a_rx_level;
  logic       a_tx_busy, a_ferr, a_perr, a_ovr;

  logic [7:0] b_tx_data, b_rx_data;
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_rxd, b_txd;
  logic [4:0] b_tx_level, b_rx_level;
  logic       b_tx_busy, b_ferr, b_perr, b_ovr;

  logic [7:0] c_tx_data, c_rx_data;
  logic       c_tx_valid, c_tx_ready, c_rx_valid, c_rx_ready, c_rxd, c_txd;
  logic [2:0] c_tx_level, c_rx_level;
  logic       c_tx_busy, c_ferr, c_perr, c_ovr;

  uart_fifo_core #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .sys_clk(clk), .reset(reset), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .uart_rxd(a_txd), .uart_txd(a_txd),
    .tx_level(a_tx_level), .rx_level(a_rx_level), .tx_busy(a_tx_busy), .rx_frame_err(a_ferr),
    .rx_parity_err(a_perr), .rx_overrun(a_ovr));

  uart_fifo_core #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
    .sys_clk(clk), .reset(reset), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .uart_rxd(b_rxd), .uart_txd(b_txd),
    .tx_level(b_tx_level), .rx_level(b_rx_level), .tx_busy(b_tx_busy), .rx_frame_err(b_ferr),
    .rx_parity_err(b_perr), .rx_overrun(b_ovr));

  uart_fifo_core #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .sys_clk(clk), .reset(reset), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .uart_rxd(c_rxd), .uart_txd(c_txd),
    .tx_level(c_tx_level), .rx_level(c_rx_level), .tx_busy(c_tx_busy), .rx_frame_err(c_ferr),
    .rx_parity_err(c_perr), .rx_overrun(c_ovr));

  int checks = 0;
  int failures = 0;
  int b_ferr_cnt = 0;
  int b_perr_cnt = 0;
  int c_ovr_cnt = 0;
  logic [7:0] a_rx_q[$];

  // Loopback bytes are popped immediately, so each is valid for exactly one cycle.
  always @(negedge clk) begin
    if (a_rx_valid) a_rx_q.push_back(a_rx_data);
    if (b_ferr) b_ferr_cnt++;
    if (b_perr) b_perr_cnt++;
    if (c_ovr) c_ovr_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveLine(input int lane, input logic v, input int n);
    if (lane == 0) b_rxd = v;
    else c_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int lane, input logic [7:0] data, input bit with_par,
                               input logic par_val, input logic stop_val);
    driveLine(lane, 1'b0, BD);
    for (int i = 0; i < 8; i++) driveLine(lane, data[i], BD);
    if (with_par) driveLine(lane, par_val, BD);
    driveLine(lane, stop_val, BD);
  endtask

  task automatic popB();
    b_rx_ready = 1'b1;
    @(negedge clk);
    b_rx_ready = 1'b0;
  endtask

  logic [9:0]  frame;
  logic [31:0] got;
  logic [7:0]  want;

  initial begin
    reset = 1'b1;
    a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b1;
    b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b0; b_rxd = 1'b1;
    c_tx_data = '0; c_tx_valid = 1'b0; c_rx_ready = 1'b0; c_rxd = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_txd", a_txd, 1);
    checkOutput("rst_tx_ready", a_tx_ready, 1);
    checkOutput("rst_rx_valid", a_rx_valid, 0);
    checkOutput("rst_tx_busy", a_tx_busy, 0);
    checkOutput("rst_rx_data", a_rx_data, 0);
    checkOutput("rst_tx_level", a_tx_level, 0);
    checkOutput("rst_rx_level", a_rx_level, 0);
    checkOutput("rst_err_pulses", {a_ferr, a_perr, a_ovr}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] 8N1 send 0xA5");
    a_tx_data = 8'hA5; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    checkOutput("tx_level_after_write", a_tx_level, 1);
    checkOutput("tx_busy_after_write", a_tx_busy, 1);
    @(negedge clk);
    checkOutput("txd_high_before_start", a_txd, 1);
    checkOutput("tx_level_after_pop", a_tx_level, 0);
    @(negedge clk);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("txd_bit%0d_first", i), a_txd, frame[i]);
      if (i == 9) checkOutput("tx_busy_in_stop", a_tx_busy, 1);
      repeat (15) @(negedge clk);
      checkOutput($sformatf("txd_bit%0d_last", i), a_txd, frame[i]);
      if (i == 9) checkOutput("tx_busy_after_160", a_tx_busy, 0);
      @(negedge clk);
    end

    $display("[TB] TX burst of 17 into 16-deep FIFO");
    for (int k = 0; k < 17; k++) begin
      checkOutput($sformatf("burst_ready%0d", k), a_tx_ready, 1);
      a_tx_data = 8'(8'h30 + k); a_tx_valid = 1'b1;
      @(negedge clk);
    end
    a_tx_data = 8'hEE;
    checkOutput("burst_full_ready", a_tx_ready, 0);
    checkOutput("burst_full_level", a_tx_level, 16);
    repeat (145) @(negedge clk);
    checkOutput("full_pop_refuses_write", a_tx_level, 15);
    @(negedge clk);
    a_tx_valid = 1'b0;
    checkOutput("late_write_level", a_tx_level, 16);
    repeat (2718) @(negedge clk);
    checkOutput("stream_busy_last_cycle", a_tx_busy, 1);
    @(negedge clk);
    checkOutput("stream_busy_done", a_tx_busy, 0);
    repeat (40) @(negedge clk);
    checkOutput("loop_count", a_rx_q.size(), 19);
    for (int k = 0; k < 19; k++) begin
      want = (k == 0) ? 8'hA5 : (k == 18) ? 8'hEE : 8'(8'h30 + k - 1);
      got  = (k < a_rx_q.size()) ? {24'h0, a_rx_q[k]} : 32'hFFFF_FFFF;
      checkOutput($sformatf("loop_byte%0d", k), got, {24'h0, want});
    end

    $display("[TB] 8E1 receive");
    applyStimulus(0, 8'h3C, 1'b1, 1'b0, 1'b1);
    checkOutput("par_ok_valid", b_rx_valid, 1);
    checkOutput("par_ok_data", b_rx_data, 8'h3C);
    checkOutput("par_ok_perr_cnt", b_perr_cnt, 0);
    checkOutput("par_ok_ferr_cnt", b_ferr_cnt, 0);
    popB();
    checkOutput("pop_to_empty_valid", b_rx_valid, 0);
    popB();
    checkOutput("pop_when_empty_level", b_rx_level, 0);
    applyStimulus(0, 8'h3C, 1'b1, 1'b1, 1'b1);
    checkOutput("par_bad_valid", b_rx_valid, 1);
    checkOutput("par_bad_data", b_rx_data, 8'h3C);
    checkOutput("par_bad_perr_cnt", b_perr_cnt, 1);
    checkOutput("par_bad_ferr_cnt", b_ferr_cnt, 0);
    popB();

    $display("[TB] glitch and framing");
    driveLine(0, 1'b0, 4);
    driveLine(0, 1'b1, 40);
    checkOutput("glitch_level", b_rx_level, 0);
    checkOutput("glitch_ferr_cnt", b_ferr_cnt, 0);
    applyStimulus(0, 8'h55, 1'b1, 1'b0, 1'b0);
    driveLine(0, 1'b0, 200);
    checkOutput("break_ferr_cnt", b_ferr_cnt, 1);
    checkOutput("break_level", b_rx_level, 1);
    checkOutput("break_data", b_rx_data, 8'h55);
    checkOutput("break_perr_cnt", b_perr_cnt, 1);
    driveLine(0, 1'b1, 20);
    applyStimulus(0, 8'hC3, 1'b1, 1'b0, 1'b1);
    checkOutput("rearm_level", b_rx_level, 2);
    checkOutput("rearm_ferr_cnt", b_ferr_cnt, 1);
    checkOutput("rearm_head", b_rx_data, 8'h55);
    popB();
    checkOutput("rearm_second", b_rx_data, 8'hC3);
    popB();
    checkOutput("rearm_drained", b_rx_level, 0);

    $display("[TB] overrun on 4-deep RX FIFO");
    for (int k = 0; k < 4; k++) applyStimulus(1, 8'(8'h11 * (k + 1)), 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_level_4", c_rx_level, 4);
    checkOutput("ovr_none_yet", c_ovr_cnt, 0);
    applyStimulus(1, 8'h55, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_level_after_5", c_rx_level, 4);
    checkOutput("ovr_pulse_cnt", c_ovr_cnt, 1);
    checkOutput("ovr_head", c_rx_data, 8'h11);

    $display("[TB] reset mid-frame");
    a_tx_data = 8'hF0; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_data = 8'h81;
    @(negedge clk);
    a_tx_valid = 1'b0;
    checkOutput("push_pop_same_cycle_level", a_tx_level, 1);
    repeat (71) @(negedge clk);
    checkOutput("midframe_bit3_low", a_txd, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_txd", a_txd, 1);
    checkOutput("midrst_tx_level", a_tx_level, 0);
    checkOutput("midrst_tx_busy", a_tx_busy, 0);
    checkOutput("midrst_tx_ready", a_tx_ready, 1);
    checkOutput("midrst_c_rx_level", c_rx_level, 0);
    checkOutput("midrst_c_rx_data", c_rx_data, 0);
    reset = 1'b0;
    @(negedge clk);
    a_tx_data = 8'h5A; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle_high", a_txd, 1);
    @(negedge clk);
    checkOutput("post_rst_start", a_txd, 0);
    repeat (16) @(negedge clk);
    checkOutput("post_rst_bit0", a_txd, 0);
    repeat (16) @(negedge clk);
    checkOutput("post_rst_bit1", a_txd, 1);
    repeat (150) @(negedge clk);
    checkOutput("post_rst_done", a_tx_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
